// File: rtl/pipo_register_pkg.sv
// Shared widths for the parallel-in parallel-out holding register.
package pipo_register_pkg;

  localparam int unsigned DATA_W = 4;

endpackage : pipo_register_pkg

// File: rtl/pipo_bit_cell.sv
// One storage bit: async-reset flop with a load-enable recirculation mux.
module pipo_bit_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic d,
  output logic q
);

  logic r_q;
  logic w_next;

  // An unknown load falls through to the hold path, so it never counts as a capture.
  always_comb begin
    w_next = r_q;
    if (load) begin
      w_next = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= RESET_BIT;
    end else begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule : pipo_bit_cell

// File: rtl/pipo_register.sv
// WIDTH-bit parallel-in parallel-out register built from independent bit cells.
module pipo_register
  import pipo_register_pkg::*;
#(
  parameter int unsigned      WIDTH       = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    pipo_bit_cell #(
      .RESET_BIT(RESET_VALUE[gi])
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .load (load),
      .d    (d[gi]),
      .q    (q[gi])
    );
  end

endmodule : pipo_register

// File: tb/tb_pipo_register.sv
// Self-checking bench: default 4-bit build plus a 16-bit build with a non-zero reset value.
module tb_pipo_register;

  localparam logic [15:0] Rv16 = 16'hA5A5;

  logic        clk;
  logic        rst;
  logic        load;
  logic [3:0]  d4;
  logic [15:0] d16;
  logic [3:0]  q4;
  logic [15:0] q16;

  // Reference: the value each register is supposed to hold right now.
  logic [3:0]  m4;
  logic [15:0] m16;

  int n_checks = 0;
  int n_pass   = 0;

  pipo_register dut4 (
    .clk  (clk),
    .reset(rst),
    .load (load),
    .d    (d4),
    .q    (q4)
  );

  pipo_register #(
    .WIDTH      (16),
    .RESET_VALUE(Rv16)
  ) dut16 (
    .clk  (clk),
    .reset(rst),
    .load (load),
    .d    (d16),
    .q    (q16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_q4"}, {12'h0, q4}, {12'h0, m4});
    check({tag, "_q16"}, q16, m16);
  endtask

  // Change inputs on the falling edge; reset acts on the model immediately.
  task automatic drive(input logic r, input logic l, input logic [3:0] a, input logic [15:0] b);
    @(negedge clk);
    rst  = r;
    load = l;
    d4   = a;
    d16  = b;
    if (r) begin
      m4  = 4'h0;
      m16 = Rv16;
    end
    #1;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) begin
      m4  = 4'h0;
      m16 = Rv16;
    end else if (load === 1'b1) begin
      m4  = d4;
      m16 = d16;
    end
    #1;
    check_both(tag);
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    d4   = 4'h0;
    d16  = 16'h0;
    m4   = 4'h0;
    m16  = Rv16;
    #1;
    check("rst_async_q4", {12'h0, q4}, 16'h0000);
    check("rst_async_q16", q16, 16'hA5A5);
    tick("rst_hold");
    tick("rst_hold");

    // Reset dominates load.
    drive(1'b1, 1'b1, 4'hF, 16'hFFFF);
    tick("rst_vs_load");
    tick("rst_vs_load");
    check("rst_vs_load_q4", {12'h0, q4}, 16'h0000);

    // First edge after release honours load; nothing changes before it.
    drive(1'b0, 1'b1, 4'hA, 16'h1234);
    check("pre_edge_q4", {12'h0, q4}, 16'h0000);
    check("pre_edge_q16", q16, 16'hA5A5);
    tick("load");
    check("load_q4", {12'h0, q4}, 16'h000A);
    check("load_q16", q16, 16'h1234);

    // Hold with d changing.
    drive(1'b0, 1'b0, 4'hC, 16'hBEEF);
    for (int i = 0; i < 20; i++) begin
      tick("hold");
    end
    check("hold_end_q4", {12'h0, q4}, 16'h000A);

    // Back-to-back loads, walking one.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 4'(1 << i), 16'(16'h0101 << i));
      tick("b2b");
    end
    check("b2b_end_q4", {12'h0, q4}, 16'h0008);

    // Async reset between edges drops the captured value without a clock.
    drive(1'b0, 1'b1, 4'hA, 16'h5A5A);
    tick("preload");
    @(negedge clk);
    load = 1'b0;
    #2;
    rst = 1'b1;
    m4  = 4'h0;
    m16 = Rv16;
    #1;
    check_both("async_mid");
    drive(1'b0, 1'b1, 4'h6, 16'h0660);
    tick("post_rst");
    check("post_rst_q4", {12'h0, q4}, 16'h0006);

    // Unknown load must not capture.
    drive(1'b0, 1'bx, 4'h9, 16'h9999);
    tick("xload");

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 15) == 0), 1'($urandom), 4'($urandom), 16'($urandom));
      check_both("rnd_async");
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule : tb_pipo_register
